// File: rtl/btn_bit_entry_pkg.sv
// +-----------------------------------------------------------------------+
// | bit_entry_pkg : shared constants for the button bit-entry front end   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package bit_entry_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int HIST_W_DEF          = 4;
    localparam int BIT_CNT_W           = 8;

endpackage

`default_nettype wire

// File: rtl/btn_bit_entry_debounce.sv
// +-----------------------------------------------------------------------+
// | btn_debounce : 2-flop synchroniser followed by a stable-level filter  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module btn_debounce
    import bit_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic fsm_clk,
    input  logic clr_n,
    input  logic i_raw,
    output logic o_stable
);

    localparam int                 c_cnt_w   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               r_s1;
    logic               r_s2;
    logic               r_stable;
    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge fsm_clk) begin
        if (!clr_n) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
            // Any return to the accepted level restarts the qualification window.
            if (r_s2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

    assign o_stable = r_stable;

endmodule

`default_nettype wire

// File: rtl/btn_bit_entry.sv
// +-----------------------------------------------------------------------+
// | btn_bit_entry : debounced bit-value + step buttons -> din/din_valid   |
// | Optional history register enabled by BTN_BIT_ENTRY_HISTORY_EN         |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module btn_bit_entry
    import bit_entry_pkg::*;
#(
`ifdef BTN_BIT_ENTRY_HISTORY_EN
    parameter int HIST_W          = HIST_W_DEF,
`endif
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                 fsm_clk,
    input  logic                 clr_n,
    input  logic                 btn_data,
    input  logic                 btn_step,
    output logic                 din,
    output logic                 din_valid,
    output logic [BIT_CNT_W-1:0] bit_cnt
`ifdef BTN_BIT_ENTRY_HISTORY_EN
    ,
    output logic [HIST_W-1:0]    history
`endif
);

    logic                 w_data_stable;
    logic                 w_step_stable;
    logic                 w_step_rise;
    logic                 r_step_prev;
    logic                 r_din;
    logic                 r_din_valid;
    logic [BIT_CNT_W-1:0] r_bit_cnt;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_data_db (
        .fsm_clk  (fsm_clk),
        .clr_n    (clr_n),
        .i_raw    (btn_data),
        .o_stable (w_data_stable)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step_db (
        .fsm_clk  (fsm_clk),
        .clr_n    (clr_n),
        .i_raw    (btn_step),
        .o_stable (w_step_stable)
    );

    // Only the press commits a bit; the release edge is ignored.
    assign w_step_rise = w_step_stable & ~r_step_prev;

    always_ff @(posedge fsm_clk) begin
        if (!clr_n) begin
            r_step_prev <= 1'b0;
            r_din       <= 1'b0;
            r_din_valid <= 1'b0;
            r_bit_cnt   <= '0;
        end else begin
            r_step_prev <= w_step_stable;
            r_din_valid <= w_step_rise;
            if (w_step_rise) begin
                r_din     <= w_data_stable;
                r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
            end
        end
    end

    assign din       = r_din;
    assign din_valid = r_din_valid;
    assign bit_cnt   = r_bit_cnt;

`ifdef BTN_BIT_ENTRY_HISTORY_EN
    logic [HIST_W-1:0] r_history;

    always_ff @(posedge fsm_clk) begin
        if (!clr_n) begin
            r_history <= '0;
        end else if (w_step_rise) begin
            r_history <= {r_history[HIST_W-2:0], w_data_stable};
        end
    end

    assign history = r_history;
`endif

endmodule

`default_nettype wire

// File: tb/tb_btn_bit_entry.sv
// +-----------------------------------------------------------------------+
// | tb_btn_bit_entry : directed self-checking bench, DEBOUNCE_CYCLES = 4  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_btn_bit_entry;

    logic       fsm_clk = 1'b0;
    logic       clr_n;
    logic       btn_data;
    logic       btn_step;
    logic       din;
    logic       din_valid;
    logic [7:0] bit_cnt;
`ifdef BTN_BIT_ENTRY_HISTORY_EN
    logic [3:0] history;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 fsm_clk = ~fsm_clk;

    btn_bit_entry #(
`ifdef BTN_BIT_ENTRY_HISTORY_EN
        .HIST_W          (4),
`endif
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .fsm_clk   (fsm_clk),
        .clr_n     (clr_n),
        .btn_data  (btn_data),
        .btn_step  (btn_step),
        .din       (din),
        .din_valid (din_valid),
        .bit_cnt   (bit_cnt)
`ifdef BTN_BIT_ENTRY_HISTORY_EN
        ,
        .history   (history)
`endif
    );

    task automatic tick();
        @(posedge fsm_clk);
        #1;
    endtask

    // Enter one bit: set data, press step for 20 cycles, release for 12.
    task automatic press_bit(input logic v, output int n, output logic d,
                             output int k_at, output logic [7:0] cnt_at);
        n = 0; d = 1'b0; k_at = -1; cnt_at = 8'h00;
        btn_data = v;
        repeat (8) tick();
        btn_step = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (din_valid === 1'b1) begin
                n++; d = din; k_at = k; cnt_at = bit_cnt;
            end
        end
        btn_step = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (din_valid === 1'b1) n++;
        end
    endtask

    task automatic pulse_reset();
        clr_n = 1'b0;
        tick();
        clr_n = 1'b1;
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            btn_data = i[0];
            btn_step = ~i[0];
            tick();
            tests_run++;
            if (din !== 1'b0 || din_valid !== 1'b0 || bit_cnt !== 8'd0) begin
                tests_failed++;
                $display("FAIL reset[%0d]: din=%b din_valid=%b bit_cnt=%0d, need 0/0/0",
                         i, din, din_valid, bit_cnt);
            end
`ifdef BTN_BIT_ENTRY_HISTORY_EN
            tests_run++;
            if (history !== 4'b0000) begin
                tests_failed++;
                $display("FAIL reset_history[%0d]: got %b need 0000", i, history);
            end
`endif
        end
        btn_data = 1'b0;
        btn_step = 1'b0;
        clr_n    = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_clean_press();
        int n = 0;
        btn_data = 1'b1;
        repeat (10) tick();
        btn_step = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            tests_run++;
            if (din_valid !== (k == 6)) begin
                tests_failed++;
                $display("FAIL clean_strobe e%0d: din_valid=%b need %b", k, din_valid, (k == 6));
            end
            if (din_valid === 1'b1) n++;
            if (k == 6) begin
                tests_run++;
                if (din !== 1'b1 || bit_cnt !== 8'd1) begin
                    tests_failed++;
                    $display("FAIL clean_value: din=%b bit_cnt=%0d need 1/1", din, bit_cnt);
                end
            end
        end
        btn_step = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (din_valid === 1'b1) n++;
        end
        tests_run++;
        if (n != 1 || bit_cnt !== 8'd1) begin
            tests_failed++;
            $display("FAIL clean_release: strobes=%0d bit_cnt=%0d need 1/1", n, bit_cnt);
        end
    endtask

    task automatic test_bounce();
        int n    = 0;
        int k_at = -1;
        btn_step = 1'b1; tick();
        btn_step = 1'b0; tick();
        btn_step = 1'b1; tick();
        btn_step = 1'b0; tick();
        tests_run++;
        if (din_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bounce_quiet: din_valid=%b need 0", din_valid);
        end
        btn_step = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (din_valid === 1'b1) begin
                n++; k_at = k;
            end
        end
        tests_run++;
        if (n != 1 || k_at != 6 || bit_cnt !== 8'd2 || din !== 1'b1) begin
            tests_failed++;
            $display("FAIL bounce: strobes=%0d at e%0d bit_cnt=%0d din=%b need 1 at e6, 2, 1",
                     n, k_at, bit_cnt, din);
        end
        btn_step = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_sequence();
        logic [3:0] bits;
        int         n;
        int         k_at;
        logic       d;
        logic [7:0] c;
        bits = 4'b0101;
        pulse_reset();
        repeat (2) tick();
        for (int i = 0; i < 4; i++) begin
            press_bit(bits[i], n, d, k_at, c);
            tests_run++;
            if (n != 1 || d !== bits[i] || k_at != 6 || c !== 8'(i + 1)) begin
                tests_failed++;
                $display("FAIL sequence[%0d]: strobes=%0d din=%b e%0d cnt=%0d need 1, %b, e6, %0d",
                         i, n, d, k_at, c, bits[i], i + 1);
            end
        end
        tests_run++;
        if (bit_cnt !== 8'd4 || din !== 1'b0) begin
            tests_failed++;
            $display("FAIL sequence_final: bit_cnt=%0d din=%b need 4/0", bit_cnt, din);
        end
`ifdef BTN_BIT_ENTRY_HISTORY_EN
        tests_run++;
        if (history !== 4'b1010) begin
            tests_failed++;
            $display("FAIL sequence_history: got %b need 1010", history);
        end
`endif
    endtask

    task automatic test_mid_reset();
        int n    = 0;
        int k_at = -1;
        btn_data = 1'b1;
        repeat (8) tick();
        btn_step = 1'b1;
        tick(); tick(); tick();
        clr_n = 1'b0;
        tick();
        tests_run++;
        if (bit_cnt !== 8'd0 || din_valid !== 1'b0 || din !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_clear: bit_cnt=%0d din_valid=%b din=%b need 0/0/0",
                     bit_cnt, din_valid, din);
        end
        clr_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (din_valid === 1'b1) begin
                n++; k_at = k;
            end
        end
        tests_run++;
        if (n != 1 || k_at != 6 || bit_cnt !== 8'd1 || din !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset: strobes=%0d at e%0d bit_cnt=%0d din=%b need 1 at e6, 1, 1",
                     n, k_at, bit_cnt, din);
        end
        btn_step = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_wrap();
        int         total = 0;
        int         n;
        int         k_at;
        logic       d;
        logic [7:0] c;
        pulse_reset();
        repeat (2) tick();
        for (int i = 0; i < 256; i++) begin
            press_bit(i[0], n, d, k_at, c);
            total += n;
            if (i == 254) begin
                tests_run++;
                if (bit_cnt !== 8'd255) begin
                    tests_failed++;
                    $display("FAIL wrap_255: bit_cnt=%0d need 255", bit_cnt);
                end
            end
        end
        tests_run++;
        if (bit_cnt !== 8'd0 || total != 256) begin
            tests_failed++;
            $display("FAIL wrap: bit_cnt=%0d strobes=%0d need 0/256", bit_cnt, total);
        end
    endtask

    task automatic test_simultaneous();
        int         n;
        int         k_at;
        logic       d;
        logic [7:0] c;
        press_bit(1'b0, n, d, k_at, c);
        tests_run++;
        if (n != 1 || din !== 1'b0) begin
            tests_failed++;
            $display("FAIL simul_setup: strobes=%0d din=%b need 1/0", n, din);
        end
        n    = 0;
        k_at = -1;
        btn_data = 1'b1;
        btn_step = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (din_valid === 1'b1) begin
                n++; k_at = k; d = din;
            end
        end
        tests_run++;
        if (n != 1 || k_at != 6 || d !== 1'b1 || bit_cnt !== 8'd2) begin
            tests_failed++;
            $display("FAIL simultaneous: strobes=%0d at e%0d din=%b bit_cnt=%0d need 1 at e6, 1, 2",
                     n, k_at, d, bit_cnt);
        end
        btn_step = 1'b0;
        repeat (12) tick();
    endtask

    initial begin
        clr_n    = 1'b0;
        btn_data = 1'b0;
        btn_step = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_sequence();
        test_mid_reset();
        test_wrap();
        test_simultaneous();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
